// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART transmitter among N requesters
module uart_tx_arbiter #(
  parameter int N       = 4,
  parameter int DBIT    = 8,
  parameter int TIMEOUT = 1000000,
  localparam int OW     = (N > 1) ? $clog2(N) : 1,
  localparam int CW     = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N-1:0]      req,
  input  logic [N*DBIT-1:0] din_bus,
  output logic [N-1:0]      grant,
  output logic [N-1:0]      ack,
  output logic              err,
  output logic [OW-1:0]     owner,
  output logic              busy,
  output logic              tx_start,
  output logic [DBIT-1:0]   tx_din,
  input  logic              tx_done_tick
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_t;

  state_t          state, state_d;
  logic [OW-1:0]   last, last_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic [N-1:0]    grant_d, ack_d;
  logic            err_d, start_d;
  logic [OW-1:0]   owner_d;
  logic [DBIT-1:0] din_d;

  logic [OW-1:0]   pick;
  logic            found;
  logic [OW:0]     idx;

  // Round-robin search: first set req bit starting just after the last owner
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= N; i++) begin
      idx = {1'b0, last} + (OW+1)'(i);
      if (idx >= (OW+1)'(N)) idx = idx - (OW+1)'(N);
      if (!found && req[idx[OW-1:0]]) begin
        found = 1'b1;
        pick  = idx[OW-1:0];
      end
    end
  end

  // Next-state and next-output logic; every output is registered below
  always_comb begin
    state_d = state;
    last_d  = last;
    cnt_d   = cnt;
    grant_d = grant;
    ack_d   = '0;
    err_d   = 1'b0;
    start_d = 1'b0;
    owner_d = owner;
    din_d   = tx_din;
    case (state)
      IDLE: begin
        if (found) begin
          state_d = ISSUE;
          grant_d = {{(N-1){1'b0}}, 1'b1} << pick;
          owner_d = pick;
          din_d   = din_bus[int'(pick)*DBIT +: DBIT];
          start_d = 1'b1;
        end
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        // completion wins over a simultaneous timeout expiry
        if (tx_done_tick) begin
          state_d = ACK;
          last_d  = owner;
          ack_d   = {{(N-1){1'b0}}, 1'b1} << owner;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          state_d = IDLE;
          last_d  = owner;
          err_d   = 1'b1;
          grant_d = '0;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      ACK: begin
        state_d = IDLE;
        grant_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset makes requester 0 first in line
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      last     <= OW'(N - 1);
      cnt      <= '0;
      grant    <= '0;
      ack      <= '0;
      err      <= 1'b0;
      tx_start <= 1'b0;
      owner    <= '0;
      tx_din   <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_d;
      last     <= last_d;
      cnt      <= cnt_d;
      grant    <= grant_d;
      ack      <= ack_d;
      err      <= err_d;
      tx_start <= start_d;
      owner    <= owner_d;
      tx_din   <= din_d;
      busy     <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int DB = 8;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  req = '0;
  logic [N*DB-1:0] din_bus = '0;
  logic [N-1:0]  grant, ack;
  logic          err, busy, tx_start;
  logic [1:0]    owner;
  logic [DB-1:0] tx_din;
  logic          tx_done_tick = 1'b0;

  int total = 0;
  int bad   = 0;

  uart_tx_arbiter #(.N(N), .DBIT(DB), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .din_bus(din_bus),
    .grant(grant), .ack(ack), .err(err), .owner(owner), .busy(busy),
    .tx_start(tx_start), .tx_din(tx_din), .tx_done_tick(tx_done_tick)
  );

  always #5 clk = ~clk;

  task automatic lit(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  // Transaction-level model: ownership is tracked by the edge it was granted on
  int       cyc = 0;
  int       g_cyc = 0;
  int       age;
  bit       m_own = 0, m_ackshow = 0, m_errshow = 0, m_found;
  int       m_owner = 0, m_last = N-1, c;
  logic [DB-1:0] m_din = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_own = 0; m_ackshow = 0; m_errshow = 0;
      m_owner = 0; m_last = N-1; m_din = '0;
    end else begin
      cyc++;
      m_errshow = 0;
      if (m_ackshow) begin
        m_ackshow = 0;
        m_own = 0;
      end else if (m_own) begin
        age = cyc - g_cyc;
        if (age >= 2) begin
          if (tx_done_tick) begin
            m_ackshow = 1; m_last = m_owner;
          end else if (age - 2 == TO - 1) begin
            m_errshow = 1; m_last = m_owner; m_own = 0;
          end
        end
      end else if (req != '0) begin
        m_found = 0;
        for (int k = 1; k <= N; k++) begin
          if (!m_found && req[(m_last + k) % N]) begin
            m_found = 1; c = (m_last + k) % N;
          end
        end
        m_own = 1; m_owner = c; m_din = din_bus[c*DB +: DB]; g_cyc = cyc;
      end
    end
  end

  // Every cycle, away from the active edge, outputs must match the model
  always @(negedge clk) begin
    lit("m_grant", grant, m_own ? (1 << m_owner) : 0);
    lit("m_ack", ack, m_ackshow ? (1 << m_owner) : 0);
    lit("m_err", err, m_errshow);
    lit("m_busy", busy, m_own);
    lit("m_start", tx_start, m_own && (cyc == g_cyc) && !m_ackshow);
    lit("m_owner", owner, m_owner);
    lit("m_tx_din", tx_din, m_din);
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_start();
    bit ok = 0;
    for (int k = 0; k < 20; k++) begin
      if (tx_start) begin ok = 1; break; end
      step();
    end
    lit("start_seen", ok, 1);
  endtask

  task automatic serve(input int who, input logic [7:0] b, input int wcyc, input bit drop);
    wait_start();
    lit("owner", owner, who);
    lit("tx_din", tx_din, b);
    lit("grant", grant, 1 << who);
    step();
    repeat (wcyc) step();
    tx_done_tick = 1; step(); tx_done_tick = 0;
    lit("ack", ack, 1 << who);
    lit("ack_err", err, 0);
    if (drop) req[who] = 1'b0;
    step();
    lit("busy_after", busy, 0);
    lit("ack_gone", ack, 0);
  endtask

  task automatic do_reset();
    reset = 1; step(); step(); reset = 0;
  endtask

  initial begin
    step(); step(); reset = 0;
    lit("rst_grant", grant, 0);
    lit("rst_busy", busy, 0);
    lit("rst_owner", owner, 0);
    lit("rst_din", tx_din, 0);
    step();

    // single requester, then the same requester again with a fresh byte
    din_bus[7:0] = 8'hA5; req = 4'b0001;
    serve(0, 8'hA5, 3, 0);
    din_bus[7:0] = 8'hB6;
    serve(0, 8'hB6, 0, 1);

    // contention from a fresh reset: 0,1,2,3
    do_reset();
    din_bus = {8'h44, 8'h33, 8'h22, 8'h11}; req = 4'b1111;
    serve(0, 8'h11, 1, 1);
    serve(1, 8'h22, 2, 1);
    serve(2, 8'h33, 0, 1);
    serve(3, 8'h44, 1, 1);

    // fairness: after owner 2, 0101 grants 0 then 2
    req = 4'b0100; serve(2, 8'h33, 0, 1);
    req = 4'b0101;
    serve(0, 8'h11, 1, 1);
    serve(2, 8'h33, 1, 1);

    // timeout: no completion, byte change after grant must not disturb tx_din
    din_bus[15:8] = 8'h5A; req = 4'b0010;
    wait_start();
    lit("to_owner", owner, 1);
    lit("to_din", tx_din, 8'h5A);
    req = 4'b0000; din_bus[15:8] = 8'hEE;
    step();
    for (int k = 1; k <= TO; k++) begin
      step();
      if (k == TO - 1) lit("to_err_early", err, 0);
      if (k == TO) begin
        lit("to_err", err, 1);
        lit("to_noack", ack, 0);
        lit("to_busy", busy, 0);
      end
    end
    step();
    lit("to_err_once", err, 0);
    lit("to_hold_din", tx_din, 8'h5A);
    din_bus[7:0] = 8'h77; req = 4'b0001;
    serve(0, 8'h77, 2, 1);

    // spurious completion while idle
    tx_done_tick = 1; step(); tx_done_tick = 0;
    lit("spur_ack", ack, 0);
    lit("spur_busy", busy, 0);
    step();

    // completion on the expiry cycle wins
    din_bus[23:16] = 8'hC3; req = 4'b0100;
    wait_start();
    step();
    repeat (TO - 1) step();
    tx_done_tick = 1; step(); tx_done_tick = 0;
    lit("edge_ack", ack, 4'b0100);
    lit("edge_err", err, 0);
    req = 4'b0000;
    step();
    lit("edge_busy", busy, 0);

    // reset in the middle of a wait
    din_bus[7:0] = 8'h99; req = 4'b0001;
    wait_start();
    step(); step();
    #3 reset = 1;
    #1;
    lit("ar_grant", grant, 0);
    lit("ar_busy", busy, 0);
    lit("ar_start", tx_start, 0);
    lit("ar_din", tx_din, 0);
    lit("ar_ack", ack, 0);
    lit("ar_err", err, 0);
    req = 4'b0000;
    step(); step(); reset = 0;
    din_bus[31:24] = 8'hD4; req = 4'b1000;
    serve(3, 8'hD4, 1, 1);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
